// File: rtl/mips_vn_memory_system_pkg.sv
// Shared memory-space definitions for the von Neumann MIPS memory system.
// Holds the region-select constants and the MMIO word offsets used for
// mem_addr[4:2]. It also holds the STATUS bit positions and the decoded
// region type.
package mips_vn_memory_system_pkg;

  // Values of mem_addr[31:20] that select each region.
  localparam logic [11:0] RAM_BASE_HI_DEF  = 12'h004;
  localparam logic [11:0] MMIO_BASE_HI_DEF = 12'h800;

  // MMIO word offsets, taken from mem_addr[4:2].
  localparam logic [2:0] MMIO_LED    = 3'd0;  // 0x00
  localparam logic [2:0] MMIO_CYCLES = 3'd1;  // 0x04
  localparam logic [2:0] MMIO_TXDATA = 3'd2;  // 0x08
  localparam logic [2:0] MMIO_STATUS = 3'd3;  // 0x0C

  // STATUS register bit positions. The FIFO count field starts at ST_COUNT_LSB.
  localparam int ST_FULL        = 0;
  localparam int ST_EMPTY       = 1;
  localparam int ST_BUS_ERROR   = 2;
  localparam int ST_TX_OVERFLOW = 3;
  localparam int ST_COUNT_LSB   = 4;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_MMIO,
    REGION_BAD
  } region_e;

endpackage

// File: rtl/mips_vn_memory_system_sync_fifo.sv
// Synchronous circular-buffer FIFO with an occupancy count.
// Ports: push/push_data write the tail. A pop removes the head, and pop is
// ignored while the FIFO is empty. head_data always shows the head entry.
// full, empty and count report occupancy. overflow pulses when a push is
// dropped: that happens on a push while full with no pop in the same cycle.
// Reset is synchronous and active-high.
module mips_vn_memory_system_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  pop_ok;
  logic                  push_ok;

  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];

  // When the FIFO is full, a pop in the same cycle frees a slot for the push.
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign overflow = push && full && !pop_ok;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values. Blocking assignments here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset. The pointers and the count decide
  // which entries are valid, and an unreset array maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mips_vn_memory_system.sv
// Unified instruction/data memory system for the multicycle von Neumann MIPS.
// Ports: mem_addr, mem_wr_data and mem_wr_ena come from the core.
// mem_rd_data returns the registered read of the address presented on the
// previous edge. leds is the LED register. tx_data and tx_valid expose the TX
// FIFO head; the consumer accepts a byte with tx_ready. bus_error is the sticky
// error flag. clk is the clock; rst is a synchronous active-high reset.
// Address map: RAM at mem_addr[31:20] == RAM_BASE_HI, with higher offset bits
// aliasing. The MMIO page is at MMIO_BASE_HI and holds LED, CYCLES, TXDATA and
// STATUS. Any other address, or any misaligned one, is a bus error.
module mips_vn_memory_system
  import mips_vn_memory_system_pkg::*;
#(
  parameter int          N             = 32,
  parameter int          RAM_AW        = 10,
  parameter logic [11:0] RAM_BASE_HI   = RAM_BASE_HI_DEF,
  parameter logic [11:0] MMIO_BASE_HI  = MMIO_BASE_HI_DEF,
  parameter int          TX_DEPTH_LOG2 = 3,
  parameter logic [N-1:0] BAD_DATA     = N'(32'hDEAD_BEEF)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] mem_addr,
  input  logic [N-1:0] mem_wr_data,
  input  logic         mem_wr_ena,
  output logic [N-1:0] mem_rd_data,
  output logic [7:0]   leds,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         bus_error
);

  localparam int CW = TX_DEPTH_LOG2 + 1;

  region_e           region;
  logic [2:0]        mmio_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              bad_access;
  logic              wr_ok, wr_ram, wr_mmio, wr_cycles, wr_tx, wr_status;
  logic [N-1:0]      ram [2**RAM_AW];
  logic [N-1:0]      cycles;
  logic [N-1:0]      status_word;
  logic [N-1:0]      rd_next;
  logic              tx_overflow;
  logic              fifo_full, fifo_empty, fifo_overflow;
  logic [CW-1:0]     fifo_count;
  logic              unused_addr_bits;

  assign mmio_off         = mem_addr[4:2];
  assign ram_idx          = mem_addr[RAM_AW+1:2];
  assign unused_addr_bits = ^mem_addr[N-13:RAM_AW+2];

  // NOTE: every combinational output gets a default first. Without it, a path
  // that leaves the output unassigned would infer a latch.
  always_comb begin
    region = REGION_BAD;
    if (mem_addr[1:0] == 2'b00) begin
      if (mem_addr[N-1:N-12] == RAM_BASE_HI)
        region = REGION_RAM;
      else if (mem_addr[N-1:N-12] == MMIO_BASE_HI && !mem_addr[4])
        region = REGION_MMIO;
    end
  end

  // A write issued during the reset cycle is not committed.
  assign bad_access = (region == REGION_BAD);
  assign wr_ok      = mem_wr_ena && !rst;
  assign wr_ram     = wr_ok && (region == REGION_RAM);
  assign wr_mmio    = wr_ok && (region == REGION_MMIO);
  assign wr_cycles  = wr_mmio && (mmio_off == MMIO_CYCLES);
  assign wr_tx      = wr_mmio && (mmio_off == MMIO_TXDATA);
  assign wr_status  = wr_mmio && (mmio_off == MMIO_STATUS);

  mips_vn_memory_system_sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (TX_DEPTH_LOG2)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_tx),
    .push_data (mem_wr_data[7:0]),
    .pop       (tx_valid && tx_ready),
    .head_data (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .overflow  (fifo_overflow)
  );

  assign tx_valid = !fifo_empty;

  always_comb begin
    status_word                      = '0;
    status_word[ST_FULL]             = fifo_full;
    status_word[ST_EMPTY]            = fifo_empty;
    status_word[ST_BUS_ERROR]        = bus_error;
    status_word[ST_TX_OVERFLOW]      = tx_overflow;
    status_word[ST_COUNT_LSB +: CW]  = fifo_count;
  end

  // The RAM term reads the pre-edge contents, so a write cycle returns the old word.
  always_comb begin
    rd_next = BAD_DATA;
    case (region)
      REGION_RAM:  rd_next = ram[ram_idx];
      REGION_MMIO: begin
        case (mmio_off)
          MMIO_LED:    rd_next = N'(leds);
          MMIO_CYCLES: rd_next = cycles;
          MMIO_TXDATA: rd_next = '0;
          MMIO_STATUS: rd_next = status_word;
          default:     rd_next = BAD_DATA;
        endcase
      end
      default:     rd_next = BAD_DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ram) ram[ram_idx] <= mem_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd_data <= '0;
      leds        <= '0;
      cycles      <= '0;
      bus_error   <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      mem_rd_data <= rd_next;
      if (wr_mmio && mmio_off == MMIO_LED) leds <= mem_wr_data[7:0];
      cycles <= wr_cycles ? '0 : cycles + N'(1);
      // A new event wins over a clearing write to STATUS in the same cycle.
      if (bad_access)         bus_error <= 1'b1;
      else if (wr_status)     bus_error <= 1'b0;
      if (fifo_overflow)      tx_overflow <= 1'b1;
      else if (wr_status)     tx_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_vn_memory_system.sv
// Self-checking bench for mips_vn_memory_system. The reference model is built
// on an associative-array RAM, a byte queue for TX and plain counters. It is
// advanced once per clock by step(), which drives the inputs and then applies
// the memory-map rules to the model.
module tb_mips_vn_memory_system;

  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wr_data = '0;
  logic        mem_wr_ena = 1'b0;
  logic [31:0] mem_rd_data;
  logic [7:0]  leds;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        bus_error;

  always #5 clk = ~clk;

  mips_vn_memory_system dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_ena  (mem_wr_ena),
    .mem_rd_data (mem_rd_data),
    .leds        (leds),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .bus_error   (bus_error)
  );

  // Reference model state.
  logic [31:0] ram_m [int];
  logic [7:0]  m_leds;
  logic [31:0] m_cycles;
  logic [7:0]  m_q [$];
  logic        m_err, m_ovf;
  logic [31:0] m_rd;
  bit          m_rd_known;

  int checks = 0;
  int errors = 0;

  function automatic bit in_ram(logic [31:0] a);
    return a[31:20] == 12'h004;
  endfunction

  function automatic bit in_mmio(logic [31:0] a);
    return a[31:20] == 12'h800;
  endfunction

  function automatic bit addr_bad(logic [31:0] a);
    if (a % 4 != 0) return 1'b1;
    if (in_ram(a)) return 1'b0;
    if (in_mmio(a) && ((a / 4) % 8) < 4) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int mmio_word(logic [31:0] a);
    return int'((a / 4) % 8);
  endfunction

  function automatic int ram_key(logic [31:0] a);
    return int'((a / 4) % 1024);
  endfunction

  task automatic model_read(input logic [31:0] a, output logic [31:0] v, output bit known);
    int n;
    n = m_q.size();
    known = 1'b1;
    v = BAD;
    if (addr_bad(a)) v = BAD;
    else if (in_ram(a)) begin
      if (ram_m.exists(ram_key(a))) v = ram_m[ram_key(a)];
      else known = 1'b0;
    end else begin
      case (mmio_word(a))
        0: v = {24'd0, m_leds};
        1: v = m_cycles;
        2: v = 32'd0;
        default: v = 32'(n * 16 + int'(m_ovf) * 8 + int'(m_err) * 4
                         + (n == 0 ? 2 : 0) + (n == 8 ? 1 : 0));
      endcase
    end
  endtask

  // Drive one cycle of inputs, wait for the edge, then advance the model.
  task automatic step(input bit r, input logic [31:0] a, input logic [31:0] d,
                      input bit we, input bit rdy);
    logic [31:0] v;
    bit k, pop, push;
    int n;
    rst = r; mem_addr = a; mem_wr_data = d; mem_wr_ena = we; tx_ready = rdy;
    model_read(a, v, k);
    n = m_q.size();
    pop = (n > 0) && rdy;
    push = we && !addr_bad(a) && in_mmio(a) && mmio_word(a) == 2;
    @(posedge clk);
    #1;
    if (r) begin
      m_rd = '0; m_rd_known = 1'b1; m_leds = '0; m_cycles = '0;
      m_q.delete(); m_err = 1'b0; m_ovf = 1'b0;
      return;
    end
    m_rd = v; m_rd_known = k;
    m_cycles = m_cycles + 1;
    if (addr_bad(a)) m_err = 1'b1;
    else if (we) begin
      if (in_ram(a)) ram_m[ram_key(a)] = d;
      else case (mmio_word(a))
        0: m_leds = d[7:0];
        1: m_cycles = '0;
        3: begin m_err = 1'b0; m_ovf = 1'b0; end
        default: ;
      endcase
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (n < 8 || pop) m_q.push_back(d[7:0]);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic test_reset();
    step(1, 32'h0040_0000, 32'h0, 0, 0);
    step(1, 32'h0040_0000, 32'h0, 0, 0);
    checks++; if (mem_rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd: got %h expected %h", mem_rd_data, 32'h0); end
    checks++; if (leds !== 8'h0) begin errors++; $display("FAIL reset_leds: got %h expected %h", leds, 8'h0); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL reset_bus_error: got %b expected 0", bus_error); end
    step(0, 32'h8000_000C, 32'h0, 0, 0);
    checks++; if (mem_rd_data !== 32'h0000_0002) begin errors++; $display("FAIL reset_status: got %h expected %h", mem_rd_data, 32'h2); end
  endtask

  task automatic test_ram_roundtrip();
    step(0, 32'h0040_0010, 32'hAAAA_0000, 1, 0);
    step(0, 32'h0040_0010, 32'h1234_5678, 1, 0);
    checks++; if (mem_rd_data !== 32'hAAAA_0000) begin errors++; $display("FAIL ram_read_before_write: got %h expected %h", mem_rd_data, 32'hAAAA_0000); end
    step(0, 32'h0040_0010, 32'h0, 0, 0);
    checks++; if (mem_rd_data !== 32'h1234_5678) begin errors++; $display("FAIL ram_roundtrip: got %h expected %h", mem_rd_data, 32'h1234_5678); end
    step(0, 32'h0041_0010, 32'h0, 0, 0);
    checks++; if (mem_rd_data !== 32'h1234_5678) begin errors++; $display("FAIL ram_alias: got %h expected %h", mem_rd_data, 32'h1234_5678); end
  endtask

  task automatic test_led_cycles();
    step(0, 32'h8000_0000, 32'hFFFF_FFA5, 1, 0);
    checks++; if (leds !== 8'hA5) begin errors++; $display("FAIL led_write: got %h expected %h", leds, 8'hA5); end
    step(0, 32'h8000_0000, 32'h0, 0, 0);
    checks++; if (mem_rd_data !== 32'h0000_00A5) begin errors++; $display("FAIL led_read: got %h expected %h", mem_rd_data, 32'hA5); end
    // The clearing edge leaves CYCLES at 0. Five idle edges bring it to 5,
    // and the read edge samples that 5.
    step(0, 32'h8000_0004, 32'h1234_0000, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 32'h0040_0010, 32'h0, 0, 0);
    step(0, 32'h8000_0004, 32'h0, 0, 0);
    checks++; if (mem_rd_data !== 32'd5) begin errors++; $display("FAIL cycles_after_clear: got %0d expected %0d", mem_rd_data, 5); end
  endtask

  task automatic test_fifo_overflow();
    logic [7:0] exp_bytes [8];
    for (int i = 1; i <= 9; i++) step(0, 32'h8000_0008, 32'(i), 1, 0);
    step(0, 32'h8000_000C, 32'h0, 0, 0);
    checks++; if (mem_rd_data !== 32'h0000_0089) begin errors++; $display("FAIL status_full_ovf: got %h expected %h", mem_rd_data, 32'h89); end
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin errors++; $display("FAIL fifo_head: got v=%b d=%h expected v=1 d=01", tx_valid, tx_data); end
    step(0, 32'h8000_000C, 32'h0, 1, 0);
    step(0, 32'h8000_0008, 32'h0000_0055, 1, 1);
    step(0, 32'h8000_000C, 32'h0, 0, 0);
    checks++; if (mem_rd_data !== 32'h0000_0081) begin errors++; $display("FAIL status_push_pop_full: got %h expected %h", mem_rd_data, 32'h81); end
    for (int i = 0; i < 7; i++) exp_bytes[i] = 8'(i + 2);
    exp_bytes[7] = 8'h55;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_bytes[i]) begin
        errors++; $display("FAIL drain_%0d: got v=%b d=%h expected v=1 d=%h", i, tx_valid, tx_data, exp_bytes[i]);
      end
      step(0, 32'h0040_0010, 32'h0, 0, 1);
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b expected 0", tx_valid); end
  endtask

  task automatic test_errors();
    step(0, 32'h0040_0000, 32'h0BAD_C0DE, 1, 0);
    step(0, 32'h1000_0000, 32'h0, 0, 0);
    checks++; if (mem_rd_data !== BAD) begin errors++; $display("FAIL unmapped_read: got %h expected %h", mem_rd_data, BAD); end
    checks++; if (bus_error !== 1'b1) begin errors++; $display("FAIL unmapped_sets_error: got %b expected 1", bus_error); end
    step(0, 32'h0040_0002, 32'hCAFE_F00D, 1, 0);
    checks++; if (mem_rd_data !== BAD) begin errors++; $display("FAIL misaligned_read: got %h expected %h", mem_rd_data, BAD); end
    step(0, 32'h0040_0000, 32'h0, 0, 0);
    checks++; if (mem_rd_data !== 32'h0BAD_C0DE) begin errors++; $display("FAIL misaligned_write_dropped: got %h expected %h", mem_rd_data, 32'h0BAD_C0DE); end
    checks++; if (bus_error !== 1'b1) begin errors++; $display("FAIL error_sticky: got %b expected 1", bus_error); end
    step(0, 32'h8000_0010, 32'h0, 0, 0);
    checks++; if (mem_rd_data !== BAD) begin errors++; $display("FAIL mmio_unmapped: got %h expected %h", mem_rd_data, BAD); end
    step(0, 32'h8000_000C, 32'h0, 1, 0);
    checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL status_clear: got %b expected 0", bus_error); end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    bit we, rdy;
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = {12'h004, 8'($urandom), 10'($urandom_range(0, 15)), 2'b00};
        4, 5, 6, 7: a = {12'h800, 15'd0, 3'($urandom_range(0, 7)), 2'b00};
        8:          a = {12'h004, 18'($urandom), 2'($urandom_range(1, 3))};
        default:    a = {12'($urandom_range(12'h100, 12'h7FF)), 20'($urandom)};
      endcase
      d   = $urandom;
      we  = ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      step(0, a, d, we, rdy);
      if (m_rd_known) begin
        checks++;
        if (mem_rd_data !== m_rd) begin errors++; $display("FAIL rand_rd[%0d] addr %h: got %h expected %h", c, a, mem_rd_data, m_rd); end
      end
      checks++;
      if (leds !== m_leds) begin errors++; $display("FAIL rand_leds[%0d]: got %h expected %h", c, leds, m_leds); end
      checks++;
      if (bus_error !== m_err) begin errors++; $display("FAIL rand_bus_error[%0d]: got %b expected %b", c, bus_error, m_err); end
      checks++;
      if (tx_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rand_tx_valid[%0d]: got %b expected %b", c, tx_valid, m_q.size() != 0); end
      if (m_q.size() != 0) begin
        checks++;
        if (tx_data !== m_q[0]) begin errors++; $display("FAIL rand_tx_data[%0d]: got %h expected %h", c, tx_data, m_q[0]); end
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    step(1, 32'h0040_0000, 32'h0, 0, 0);
    step(0, 32'h0040_0020, 32'h600D_F00D, 1, 0);
    step(0, 32'h8000_0000, 32'h0000_003C, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 32'h8000_0008, 32'(8'hA0 + i), 1, 0);
    checks++; if (tx_valid !== 1'b1 || leds !== 8'h3C) begin errors++; $display("FAIL pre_reset_state: got v=%b leds=%h expected v=1 leds=3c", tx_valid, leds); end
    step(1, 32'h0040_0020, 32'hFFFF_FFFF, 1, 1);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL midreset_tx_valid: got %b expected 0", tx_valid); end
    checks++; if (leds !== 8'h0) begin errors++; $display("FAIL midreset_leds: got %h expected 00", leds); end
    checks++; if (mem_rd_data !== 32'h0) begin errors++; $display("FAIL midreset_rd: got %h expected 0", mem_rd_data); end
    step(0, 32'h0040_0020, 32'h0, 0, 0);
    checks++; if (mem_rd_data !== 32'h600D_F00D) begin errors++; $display("FAIL ram_survives_reset: got %h expected %h", mem_rd_data, 32'h600D_F00D); end
  endtask

  initial begin
    test_reset();
    test_ram_roundtrip();
    test_led_cycles();
    test_fifo_overflow();
    test_errors();
    test_random();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
